// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-synchronous, double-buffered display contents.
// Latency: an IDLE load shows on the next cycle; a SCAN load shows at the next frame boundary (worst case NUM_DIGITS*DIV cycles).
// Backpressure: none. A newer load before commit replaces the shadow, and the last load wins.
//
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   enable       - 1 = scan the digits, 0 = display dark (IDLE)
//   load         - single-cycle strobe that captures load_codes/load_blank
//   load_codes   - 3-bit code per digit; digit i is bits [3i+2:3i]
//   load_blank   - per-digit blank mask; 1 = digit kept dark
//   digit_code   - code of the scanned digit, to the shared decoder
//   digit_en     - one-hot, active-high enable of the scanned digit
//   pending      - shadow holds a load that is not yet committed
//   frame_done   - one-cycle pulse after the last digit's dwell ends
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int DIV        = 50000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      load,
   input  logic [3*NUM_DIGITS-1:0]   load_codes,
   input  logic [NUM_DIGITS-1:0]     load_blank,
   output logic [2:0]                digit_code,
   output logic [NUM_DIGITS-1:0]     digit_en,
   output logic                      pending,
   output logic                      frame_done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t                    state, state_nxt;
   logic [CW-1:0]             cnt, cnt_nxt;
   logic [IW-1:0]             idx, idx_nxt;
   logic [3*NUM_DIGITS-1:0]   active_codes, active_codes_nxt;
   logic [NUM_DIGITS-1:0]     active_blank, active_blank_nxt;
   logic [3*NUM_DIGITS-1:0]   shadow_codes, shadow_codes_nxt;
   logic [NUM_DIGITS-1:0]     shadow_blank, shadow_blank_nxt;
   logic                      pending_nxt;
   logic                      frame_done_nxt;
   logic                      tick;
   logic                      boundary;

   assign tick     = (cnt == CNT_MAX);
   assign boundary = tick && (idx == IDX_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         active_codes <= '0;
         active_blank <= '0;
         shadow_codes <= '0;
         shadow_blank <= '0;
         pending      <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         idx          <= idx_nxt;
         active_codes <= active_codes_nxt;
         active_blank <= active_blank_nxt;
         shadow_codes <= shadow_codes_nxt;
         shadow_blank <= shadow_blank_nxt;
         pending      <= pending_nxt;
         frame_done   <= frame_done_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      cnt_nxt          = cnt;
      idx_nxt          = idx;
      active_codes_nxt = active_codes;
      active_blank_nxt = active_blank;
      shadow_codes_nxt = shadow_codes;
      shadow_blank_nxt = shadow_blank;
      pending_nxt      = pending;
      frame_done_nxt   = 1'b0;

      case (state)
         IDLE: begin
            cnt_nxt     = '0;
            idx_nxt     = '0;
            pending_nxt = 1'b0;
            // Nothing is on display, so a load cannot tear a frame. Write it straight through.
            if (load) begin
               active_codes_nxt = load_codes;
               active_blank_nxt = load_blank;
            end
            if (enable) begin
               state_nxt = SCAN;
            end
         end

         SCAN: begin
            if (!enable) begin
               // On the way out, flush the newest contents into active so the
               // next scan does not start from stale data. A load on this same
               // edge is newer than the shadow.
               state_nxt   = IDLE;
               cnt_nxt     = '0;
               idx_nxt     = '0;
               pending_nxt = 1'b0;
               if (load) begin
                  active_codes_nxt = load_codes;
                  active_blank_nxt = load_blank;
               end else if (pending) begin
                  active_codes_nxt = shadow_codes;
                  active_blank_nxt = shadow_blank;
               end
            end else begin
               cnt_nxt = tick ? '0 : cnt + 1'b1;
               if (tick) begin
                  idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;
               end
               if (boundary) begin
                  frame_done_nxt = 1'b1;
                  pending_nxt    = 1'b0;
                  // A load that lands on the wrap edge bypasses the shadow and
                  // discards any older shadow contents.
                  if (load) begin
                     active_codes_nxt = load_codes;
                     active_blank_nxt = load_blank;
                  end else if (pending) begin
                     active_codes_nxt = shadow_codes;
                     active_blank_nxt = shadow_blank;
                  end
               end else if (load) begin
                  shadow_codes_nxt = load_codes;
                  shadow_blank_nxt = load_blank;
                  pending_nxt      = 1'b1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Decode outputs from registers only. A blanked digit still shows its
   // code, and only its enable is suppressed.
   always_comb begin
      digit_code = '0;
      digit_en   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            digit_code  = active_codes[3*i +: 3];
            digit_en[i] = (state == SCAN) && !active_blank[i];
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

   localparam int N     = 4;
   localparam int D     = 4;
   localparam int FRAME = N * D;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b0;
   logic             load = 1'b0;
   logic [3*N-1:0]   load_codes = '0;
   logic [N-1:0]     load_blank = '0;
   logic [2:0]       digit_code;
   logic [N-1:0]     digit_en;
   logic             pending;
   logic             frame_done;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.NUM_DIGITS(N), .DIV(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .load_codes (load_codes),
      .load_blank (load_blank),
      .digit_code (digit_code),
      .digit_en   (digit_en),
      .pending    (pending),
      .frame_done (frame_done)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: time since scan start, plus what is displayed and what is queued.
   bit m_scan;
   int m_t;
   int m_act_code [N];
   bit m_act_blank[N];
   int m_sh_code  [N];
   bit m_sh_blank [N];
   bit m_pend;
   bit m_fd;

   task automatic model_reset();
      m_scan = 0; m_t = 0; m_pend = 0; m_fd = 0;
      for (int i = 0; i < N; i++) begin
         m_act_code[i] = 0; m_act_blank[i] = 0;
         m_sh_code[i]  = 0; m_sh_blank[i]  = 0;
      end
   endtask

   task automatic take_active(input logic [3*N-1:0] c, input logic [N-1:0] b);
      for (int i = 0; i < N; i++) begin
         m_act_code[i]  = int'(c[3*i +: 3]);
         m_act_blank[i] = b[i];
      end
   endtask

   task automatic commit_shadow();
      for (int i = 0; i < N; i++) begin
         m_act_code[i]  = m_sh_code[i];
         m_act_blank[i] = m_sh_blank[i];
      end
   endtask

   task automatic model_edge(input logic en, input logic ld,
                             input logic [3*N-1:0] c, input logic [N-1:0] b);
      bit bnd;
      if (!m_scan) begin
         m_fd = 0;
         if (ld) take_active(c, b);
         if (en) begin
            m_scan = 1;
            m_t    = 0;
         end
      end else if (!en) begin
         if (ld) take_active(c, b);
         else if (m_pend) commit_shadow();
         m_pend = 0;
         m_scan = 0;
         m_fd   = 0;
      end else begin
         bnd = ((m_t % FRAME) == FRAME - 1);
         if (bnd) begin
            if (ld) take_active(c, b);
            else if (m_pend) commit_shadow();
            m_pend = 0;
         end else if (ld) begin
            for (int i = 0; i < N; i++) begin
               m_sh_code[i]  = int'(c[3*i +: 3]);
               m_sh_blank[i] = b[i];
            end
            m_pend = 1;
         end
         m_fd = bnd;
         m_t  = m_t + 1;
      end
   endtask

   function automatic int cur_digit();
      return m_scan ? ((m_t / D) % N) : 0;
   endfunction

   task automatic check_outputs();
      int d;
      int exp_en;
      d      = cur_digit();
      exp_en = (m_scan && !m_act_blank[d]) ? (1 << d) : 0;
      chk("digit_code", 32'(digit_code), m_act_code[d]);
      chk("digit_en",   32'(digit_en),   exp_en);
      chk("pending",    32'(pending),    32'(m_pend));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("onehot",     32'($countones(digit_en) <= 1), 32'd1);
   endtask

   task automatic cyc(input logic en, input logic ld,
                      input logic [3*N-1:0] c, input logic [N-1:0] b);
      enable = en; load = ld; load_codes = c; load_blank = b;
      @(posedge clk);
      model_edge(en, ld, c, b);
      #1;
      check_outputs();
   endtask

   function automatic logic [3*N-1:0] pack(input int d3, input int d2, input int d1, input int d0);
      return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
   endfunction

   initial begin
      model_reset();
      rst_n = 1'b0;
      #12;
      check_outputs();
      rst_n = 1'b1;

      // Scan after reset with no load
      repeat (40) cyc(1, 0, '0, '0);

      // Load in IDLE, then scan
      cyc(0, 0, '0, '0);
      cyc(0, 1, pack(4, 3, 2, 1), '0);
      repeat (20) cyc(1, 0, '0, '0);

      // Load in the middle of the frame, during digit 1's dwell
      for (int k = 0; k < FRAME && cur_digit() != 1; k++) cyc(1, 0, '0, '0);
      cyc(1, 1, pack(0, 0, 0, 4), '0);
      repeat (20) cyc(1, 0, '0, '0);

      // Two loads within one frame
      for (int k = 0; k < FRAME && (m_t % FRAME) != 0; k++) cyc(1, 0, '0, '0);
      cyc(1, 1, pack(7, 6, 5, 5), '0);
      repeat (5) cyc(1, 0, '0, '0);
      cyc(1, 1, pack(1, 2, 3, 0), '0);
      repeat (20) cyc(1, 0, '0, '0);

      // Load on the exact wrap cycle
      for (int k = 0; k < FRAME && (m_t % FRAME) != FRAME - 1; k++) cyc(1, 0, '0, '0);
      cyc(1, 1, pack(2, 7, 1, 6), '0);
      repeat (6) cyc(1, 0, '0, '0);

      // Blank mask
      cyc(1, 1, pack(3, 3, 3, 3), 4'b1010);
      repeat (40) cyc(1, 0, '0, '0);

      // Drop enable while a load is still pending
      for (int k = 0; k < FRAME && cur_digit() != 1; k++) cyc(1, 0, '0, '0);
      cyc(1, 1, pack(5, 4, 3, 2), 4'b0100);
      cyc(1, 0, '0, '0);
      cyc(0, 0, '0, '0);
      repeat (3) cyc(0, 0, '0, '0);
      repeat (10) cyc(1, 0, '0, '0);

      // Asynchronous reset in the middle of a dwell
      cyc(1, 1, pack(6, 5, 4, 7), '0);
      repeat (22) cyc(1, 0, '0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_code",  32'(digit_code), 32'd0);
      chk("arst_en",    32'(digit_en),   32'd0);
      chk("arst_pend",  32'(pending),    32'd0);
      chk("arst_fdone", 32'(frame_done), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;
      repeat (20) cyc(1, 0, '0, '0);

      // Random traffic
      for (int k = 0; k < 800; k++) begin
         cyc(($urandom_range(0, 24) != 0), ($urandom_range(0, 5) == 0),
             12'($urandom), 4'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
